// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer: register map,
// per-mode parameter table, FSM state type and the write-slot decode helpers.
package pll_reconfig_pkg;

    localparam logic [5:0] ADDR_MODE  = 6'd0;
    localparam logic [5:0] ADDR_START = 6'd2;
    localparam logic [5:0] ADDR_N     = 6'd3;
    localparam logic [5:0] ADDR_M     = 6'd4;
    localparam logic [5:0] ADDR_C     = 6'd5;
    localparam logic [5:0] ADDR_K     = 6'd7;
    localparam logic [5:0] ADDR_BW    = 6'd8;
    localparam logic [5:0] ADDR_CP    = 6'd9;

    typedef struct packed {
        logic [31:0] n;
        logic [31:0] m;
        logic [31:0] c0;
        logic [31:0] k;
        logic [31:0] bw;
        logic [31:0] cp;
    } pll_params_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        SETTLE,
        DONE
    } state_t;

    localparam pll_params_t PLL_TABLE [8] = '{
        '{32'h0000_0101, 32'h0000_0214, 32'h0000_0302, 32'h0000_0000, 32'h0000_0006, 32'h0000_0002},
        '{32'h0000_0102, 32'h0000_0228, 32'h0000_0304, 32'h1999_999A, 32'h0000_0007, 32'h0000_0003},
        '{32'h0000_0103, 32'h0000_023C, 32'h0000_0306, 32'h3333_3333, 32'h0000_0008, 32'h0000_0004},
        '{32'h0000_0104, 32'h0000_0250, 32'h0000_0308, 32'h4CCC_CCCD, 32'h0000_0009, 32'h0000_0005},
        '{32'h0000_0105, 32'h0000_0264, 32'h0000_030A, 32'h6666_6666, 32'h0000_000A, 32'h0000_0006},
        '{32'h0000_0106, 32'h0000_0278, 32'h0000_030C, 32'h8000_0000, 32'h0000_000B, 32'h0000_0007},
        '{32'h0000_0107, 32'h0000_028C, 32'h0000_030E, 32'h9999_999A, 32'h0000_000C, 32'h0000_0008},
        '{32'h0000_0108, 32'h0000_02A0, 32'h0000_0310, 32'hB333_3333, 32'h0000_000D, 32'h0000_0009}
    };

    // Slots follow the fixed write order: MODE, N, M, C0, K, BW, CP, START.
    function automatic logic [5:0] slot_addr(input logic [2:0] slot);
        logic [5:0] a;
        case (slot)
            3'd0:    a = ADDR_MODE;
            3'd1:    a = ADDR_N;
            3'd2:    a = ADDR_M;
            3'd3:    a = ADDR_C;
            3'd4:    a = ADDR_K;
            3'd5:    a = ADDR_BW;
            3'd6:    a = ADDR_CP;
            default: a = ADDR_START;
        endcase
        return a;
    endfunction

    function automatic logic [31:0] slot_value(input pll_params_t p, input logic [2:0] slot);
        logic [31:0] v;
        case (slot)
            3'd1:    v = p.n;
            3'd2:    v = p.m;
            3'd3:    v = p.c0;
            3'd4:    v = p.k;
            3'd5:    v = p.bw;
            3'd6:    v = p.cp;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: streams one parameter-table entry into the
// reconfig write FIFO, then waits out the settle time. PLL_RECONFIG_FRAC_EN adds the K write.
module pll_reconfig_seq
    import pll_reconfig_pkg::*;
#(
    parameter int NUM_MODES     = 4,
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic [2:0]  mode_sel,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [5:0]  pll_addr,
    output logic [31:0] pll_value,
    output logic        pll_write,
    input  logic        pll_busy
);

`ifdef PLL_RECONFIG_FRAC_EN
    localparam logic [2:0] LAST_STEP = 3'd7;
`else
    localparam logic [2:0] LAST_STEP = 3'd6;
`endif
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [15:0] settle_q, settle_d;
    logic [2:0]  mode_q, mode_d;
    logic        err_d;
    logic [2:0]  slot_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            step_q    <= 3'd0;
            settle_q  <= 16'd0;
            mode_q    <= 3'd0;
            err       <= 1'b0;
            pll_addr  <= 6'd0;
            pll_value <= 32'd0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            settle_q <= settle_d;
            mode_q   <= mode_d;
            err      <= err_d;
            if (state_d == WRITE) begin
                pll_addr  <= slot_addr(slot_d);
                pll_value <= slot_value(PLL_TABLE[mode_d], slot_d);
            end else begin
                pll_addr  <= 6'd0;
                pll_value <= 32'd0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        settle_d = settle_q;
        mode_d   = mode_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (int'(mode_sel) < NUM_MODES) begin
                        mode_d  = mode_sel;
                        step_d  = 3'd0;
                        state_d = WRITE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (!pll_busy) begin
                    if (step_q == LAST_STEP) begin
                        settle_d = 16'd0;
                        state_d  = SETTLE;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = DONE;
                end else begin
                    settle_d = settle_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Without the fractional option the K slot is stepped over entirely.
    always_comb begin
`ifdef PLL_RECONFIG_FRAC_EN
        slot_d = step_d;
`else
        slot_d = (step_d >= 3'd4) ? step_d + 3'd1 : step_d;
`endif
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign pll_write = reset_n && (state_q == WRITE) && !pll_busy;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Scoreboard bench for pll_reconfig_seq; expected FIFO writes are queued when a
// request is driven and checked by a monitor as the DUT issues them.
module tb_pll_reconfig_seq;
    import pll_reconfig_pkg::*;

    localparam int NUM_MODES = 4;
    localparam int SETTLE    = 20;
`ifdef PLL_RECONFIG_FRAC_EN
    localparam int NWR = 8;
`else
    localparam int NWR = 7;
`endif

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] value;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req;
    logic [2:0]  mode_sel;
    logic        busy, done, err;
    logic [5:0]  pll_addr;
    logic [31:0] pll_value;
    logic        pll_write;
    logic        pll_busy;

    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  writes_total = 0;
    int  done_total = 0;
    int  start_cyc = 0;
    int  first_cyc = 0;
    wr_t exp_q[$];

    pll_reconfig_seq #(.NUM_MODES(NUM_MODES), .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .mode_sel(mode_sel),
        .busy(busy), .done(done), .err(err), .pll_addr(pll_addr),
        .pll_value(pll_value), .pll_write(pll_write), .pll_busy(pll_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (pll_write) begin
            wr_t e;
            writes_total++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_write: got addr=%0d value=%h, expected no write", pll_addr, pll_value);
            end else begin
                e = exp_q.pop_front();
                if (pll_addr !== e.addr || pll_value !== e.value) begin
                    errors++;
                    $display("[TB] FAIL write_entry: got addr=%0d value=%h, expected addr=%0d value=%h",
                             pll_addr, pll_value, e.addr, e.value);
                end
            end
            if (pll_addr == ADDR_MODE) first_cyc = cyc;
            if (pll_addr == ADDR_START) start_cyc = cyc;
        end
        if (done) begin
            done_total++;
            checks++;
            if (cyc - start_cyc !== SETTLE + 1) begin
                errors++;
                $display("[TB] FAIL done_timing: got %0d cycles after start write, expected %0d",
                         cyc - start_cyc, SETTLE + 1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_sequence(input int mode);
        pll_params_t p;
        p = PLL_TABLE[mode];
        exp_q.push_back('{6'd0, 32'h0});
        exp_q.push_back('{6'd3, p.n});
        exp_q.push_back('{6'd4, p.m});
        exp_q.push_back('{6'd5, p.c0});
`ifdef PLL_RECONFIG_FRAC_EN
        exp_q.push_back('{6'd7, p.k});
`endif
        exp_q.push_back('{6'd8, p.bw});
        exp_q.push_back('{6'd9, p.cp});
        exp_q.push_back('{6'd2, 32'h0});
    endtask

    task automatic send_req(input logic [2:0] mode);
        req = 1'b1;
        mode_sel = mode;
        tick(1);
        req = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick(1);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL done_timeout: got no done within %0d cycles, expected done", limit);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        tick(2);
        checks++;
        if ({busy, done, err, pll_write} !== 4'b0 || pll_addr !== 6'd0 || pll_value !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: got busy=%b done=%b err=%b wr=%b addr=%0d value=%h, expected all 0",
                     busy, done, err, pll_write, pll_addr, pll_value);
        end
        reset_n = 1'b1;
        tick(1);
    endtask

    task automatic test_sequence(input logic [2:0] mode);
        int w0 = writes_total;
        int d0 = done_total;
        push_sequence(mode);
        send_req(mode);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_rise: got %b, expected 1", busy);
        end
        wait_done(NWR + SETTLE + 20);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL busy_in_done: got %b, expected 1", busy);
        end
        tick(1);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL after_done: got busy=%b done=%b, expected 0 0", busy, done);
        end
        checks++;
        if (writes_total - w0 !== NWR || done_total - d0 !== 1) begin
            errors++;
            $display("[TB] FAIL seq_counts: got writes=%0d dones=%0d, expected %0d 1",
                     writes_total - w0, done_total - d0, NWR);
        end
        checks++;
        if (start_cyc - first_cyc !== NWR - 1 || exp_q.size() !== 0) begin
            errors++;
            $display("[TB] FAIL seq_contiguous: got span=%0d pending=%0d, expected %0d 0",
                     start_cyc - first_cyc, exp_q.size(), NWR - 1);
        end
    endtask

    task automatic test_backpressure;
        int w0 = writes_total;
        push_sequence(2);
        send_req(3'd2);
        tick(2);
        pll_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (pll_write !== 1'b0) begin
                errors++;
                $display("[TB] FAIL stall_write: got %b in stall cycle %0d, expected 0", pll_write, i);
            end
            tick(1);
        end
        pll_busy = 1'b0;
        wait_done(NWR + SETTLE + 20);
        tick(1);
        checks++;
        if (writes_total - w0 !== NWR || exp_q.size() !== 0 || start_cyc - first_cyc !== NWR + 4) begin
            errors++;
            $display("[TB] FAIL stall_counts: got writes=%0d pending=%0d span=%0d, expected %0d 0 %0d",
                     writes_total - w0, exp_q.size(), start_cyc - first_cyc, NWR, NWR + 4);
        end
    endtask

    task automatic test_invalid;
        int w0 = writes_total;
        send_req(3'd5);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL invalid_err: got err=%b busy=%b, expected 1 0", err, busy);
        end
        tick(1);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_pulse_width: got err=%b, expected 0", err);
        end
        tick(5);
        checks++;
        if (writes_total !== w0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL invalid_writes: got writes=%0d busy=%b, expected 0 0", writes_total - w0, busy);
        end
    endtask

    task automatic test_reset_mid;
        int w0 = writes_total;
        int d0 = done_total;
        push_sequence(3);
        send_req(3'd3);
        tick(3);
        reset_n = 1'b0;
        #1;
        checks++;
        if (pll_write !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_write_gate: got %b, expected 0", pll_write);
        end
        tick(1);
        reset_n = 1'b1;
        exp_q.delete();
        checks++;
        if (writes_total - w0 !== 3 || busy !== 1'b0 || pll_addr !== 6'd0) begin
            errors++;
            $display("[TB] FAIL reset_abort: got writes=%0d busy=%b addr=%0d, expected 3 0 0",
                     writes_total - w0, busy, pll_addr);
        end
        tick(SETTLE + 10);
        checks++;
        if (done_total !== d0 || writes_total - w0 !== 3) begin
            errors++;
            $display("[TB] FAIL reset_no_resume: got dones=%0d writes=%0d, expected 0 3",
                     done_total - d0, writes_total - w0);
        end
        test_sequence(3'd0);
    endtask

    task automatic test_ignored;
        int w0 = writes_total;
        int d0 = done_total;
        push_sequence(1);
        send_req(3'd1);
        tick(2);
        send_req(3'd2);
        wait_done(NWR + SETTLE + 20);
        send_req(3'd0);
        tick(SETTLE + NWR + 10);
        checks++;
        if (done_total - d0 !== 1 || writes_total - w0 !== NWR || busy !== 1'b0 || exp_q.size() !== 0) begin
            errors++;
            $display("[TB] FAIL ignored_req: got dones=%0d writes=%0d busy=%b pending=%0d, expected 1 %0d 0 0",
                     done_total - d0, writes_total - w0, busy, exp_q.size(), NWR);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        req      = 1'b0;
        mode_sel = 3'd0;
        pll_busy = 1'b0;
        test_reset();
        test_sequence(3'd1);
        test_sequence(3'd3);
        test_backpressure();
        test_invalid();
        test_reset_mid();
        test_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
